// File: rtl/packet_detector_axil_regs_if.sv
// AXI4-Lite slave bus bundle for the packet detector register block.
interface packet_detector_axil_regs_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/packet_detector_axil_regs.sv
// AXI4-Lite register file for the packet detector: four RW config words,
// a saturating detection counter and a status word.
module packet_detector_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                          s00_axi_aclk,
  input  logic                          s00_axi_areset,
  packet_detector_axil_regs_if.slave    s00_axi,
  input  logic                          det_pulse,
  input  logic                          det_busy,
  output logic [C_S_AXI_DATA_WIDTH-1:0] ctrl,
  output logic [C_S_AXI_DATA_WIDTH-1:0] threshold,
  output logic [C_S_AXI_DATA_WIDTH-1:0] window,
  output logic [C_S_AXI_DATA_WIDTH-1:0] scratch
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam logic [DW-1:0] CNT_MAX = '1;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  wstate_t r_wstate, w_wstate_nxt;
  rstate_t r_rstate, w_rstate_nxt;

  logic          r_rst_done;
  logic          r_aw_have, r_w_have;
  logic [2:0]    r_aw_idx;
  logic [DW-1:0] r_wdata;
  logic [3:0]    r_wstrb;
  logic [DW-1:0] r_ctrl, r_thresh, r_window, r_scratch, r_count;
  logic          r_sat;
  logic [1:0]    r_bresp;
  logic [DW-1:0] r_rdata;

  logic [C_S_AXI_ADDR_WIDTH-1:0] w_awaddr, w_araddr;
  logic          w_awready, w_wready, w_arready;
  logic          w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_clear;
  logic [2:0]    w_idx;
  logic [DW-1:0] w_data, w_rword;
  logic [3:0]    w_strb;
  logic          w_unused;

  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [3:0]    strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  assign w_awaddr = s00_axi.awaddr;
  assign w_araddr = s00_axi.araddr;
  assign w_unused = ^{s00_axi.awprot, s00_axi.arprot, w_awaddr[1:0], w_araddr[1:0]};

  always_comb begin
    w_awready    = r_rst_done && (r_wstate == W_IDLE) && !r_aw_have;
    w_wready     = r_rst_done && (r_wstate == W_IDLE) && !r_w_have;
    w_arready    = r_rst_done && (r_rstate == R_IDLE);
    w_aw_hs      = s00_axi.awvalid && w_awready;
    w_w_hs       = s00_axi.wvalid && w_wready;
    w_ar_hs      = s00_axi.arvalid && w_arready;
    // AW and W may arrive in either order; commit on the edge the second one lands.
    w_idx        = r_aw_have ? r_aw_idx : w_awaddr[4:2];
    w_data       = r_w_have ? r_wdata : s00_axi.wdata;
    w_strb       = r_w_have ? r_wstrb : s00_axi.wstrb;
    w_commit     = (r_aw_have || w_aw_hs) && (r_w_have || w_w_hs);
    w_clear      = w_commit && (w_idx == 3'd0) && w_strb[0] && w_data[1];
    w_wstate_nxt = r_wstate;
    w_rstate_nxt = r_rstate;
    case (r_wstate)
      W_IDLE:  if (w_commit) w_wstate_nxt = W_RESP;
      W_RESP:  if (s00_axi.bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
    case (r_rstate)
      R_IDLE:  if (w_ar_hs) w_rstate_nxt = R_DATA;
      R_DATA:  if (s00_axi.rready) w_rstate_nxt = R_IDLE;
      default: w_rstate_nxt = R_IDLE;
    endcase
    w_rword = '0;
    case (w_araddr[4:2])
      3'd0:    w_rword = r_ctrl;
      3'd1:    w_rword = r_thresh;
      3'd2:    w_rword = r_window;
      3'd3:    w_rword = r_scratch;
      3'd4:    w_rword = r_count;
      3'd5:    w_rword = DW'({det_busy, r_sat});
      default: w_rword = '0;
    endcase
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_wstate   <= W_IDLE;
      r_rstate   <= R_IDLE;
      r_rst_done <= 1'b0;
      r_aw_have  <= 1'b0;
      r_w_have   <= 1'b0;
      r_aw_idx   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bresp    <= 2'b00;
      r_rdata    <= '0;
    end else begin
      r_wstate   <= w_wstate_nxt;
      r_rstate   <= w_rstate_nxt;
      r_rst_done <= 1'b1;
      if (w_commit) begin
        r_aw_have <= 1'b0;
        r_w_have  <= 1'b0;
        r_bresp   <= w_idx[2] ? 2'b10 : 2'b00;
      end else begin
        if (w_aw_hs) begin
          r_aw_have <= 1'b1;
          r_aw_idx  <= w_awaddr[4:2];
        end
        if (w_w_hs) begin
          r_w_have <= 1'b1;
          r_wdata  <= s00_axi.wdata;
          r_wstrb  <= s00_axi.wstrb;
        end
      end
      if (w_ar_hs) r_rdata <= w_rword;
    end
  end

  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      r_ctrl    <= '0;
      r_thresh  <= '0;
      r_window  <= '0;
      r_scratch <= '0;
      r_count   <= '0;
      r_sat     <= 1'b0;
    end else begin
      if (w_commit) begin
        case (w_idx)
          // CTRL[1] is a clear strobe and never stays set.
          3'd0:    r_ctrl    <= apply_strb(r_ctrl, w_data, w_strb) & ~DW'(2);
          3'd1:    r_thresh  <= apply_strb(r_thresh, w_data, w_strb);
          3'd2:    r_window  <= apply_strb(r_window, w_data, w_strb);
          3'd3:    r_scratch <= apply_strb(r_scratch, w_data, w_strb);
          default: ;
        endcase
      end
      if (w_clear) begin
        r_count <= '0;
        r_sat   <= 1'b0;
      end else if (det_pulse) begin
        if (r_count == CNT_MAX) begin
          r_sat <= 1'b1;
        end else begin
          r_count <= r_count + DW'(1);
          if (r_count == CNT_MAX - DW'(1)) r_sat <= 1'b1;
        end
      end
    end
  end

  assign s00_axi.awready = w_awready;
  assign s00_axi.wready  = w_wready;
  assign s00_axi.arready = w_arready;
  assign s00_axi.bvalid  = (r_wstate == W_RESP);
  assign s00_axi.bresp   = r_bresp;
  assign s00_axi.rvalid  = (r_rstate == R_DATA);
  assign s00_axi.rdata   = r_rdata;
  assign s00_axi.rresp   = 2'b00;
  assign ctrl            = r_ctrl;
  assign threshold       = r_thresh;
  assign window          = r_window;
  assign scratch         = r_scratch;
endmodule

// File: tb/tb_packet_detector_axil_regs.sv
// Directed bench for packet_detector_axil_regs with response scoreboards.
module tb_packet_detector_axil_regs;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        det_pulse = 1'b0;
  logic        det_busy = 1'b0;
  logic [31:0] ctrl, threshold, window, scratch;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] rq[$];
  logic [1:0]  bq[$];

  always #5 clk = ~clk;

  packet_detector_axil_regs_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  packet_detector_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) dut (
    .s00_axi_aclk   (clk),
    .s00_axi_areset (rst),
    .s00_axi        (bus),
    .det_pulse      (det_pulse),
    .det_busy       (det_busy),
    .ctrl           (ctrl),
    .threshold      (threshold),
    .window         (window),
    .scratch        (scratch)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input logic [1:0] er, input int bdly);
    logic awr, wr;
    logic [1:0] eb;
    int n;
    bq.push_back(er);
    @(negedge clk);
    bus.awaddr = a; bus.awvalid = 1'b1;
    bus.wdata = d; bus.wstrb = s; bus.wvalid = 1'b1;
    bus.bready = (bdly == 0);
    n = 0;
    while ((bus.awvalid || bus.wvalid) && n < 20) begin
      awr = bus.awready; wr = bus.wready;
      @(posedge clk); #1;
      if (awr) bus.awvalid = 1'b0;
      if (wr) bus.wvalid = 1'b0;
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus.bvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    eb = bq.pop_front();
    if (n >= 20) begin
      check("wr_timeout", 32'(bus.bvalid), 32'd1);
      bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    end else begin
      det_pulse = 1'b0;
      check("bresp", 32'(bus.bresp), 32'(eb));
      for (int i = 0; i < bdly; i++) begin
        @(negedge clk);
        check("bhold_bvalid", 32'(bus.bvalid), 32'd1);
        check("bhold_bresp", 32'(bus.bresp), 32'(eb));
        check("bhold_awready", 32'(bus.awready), 32'd0);
        check("bhold_wready", 32'(bus.wready), 32'd0);
      end
      bus.bready = 1'b1;
      @(posedge clk); #1;
      bus.bready = 1'b0;
      @(negedge clk);
      check("bvalid_drop", 32'(bus.bvalid), 32'd0);
    end
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] exp);
    logic arr;
    logic [31:0] e;
    int n;
    rq.push_back(exp);
    @(negedge clk);
    bus.araddr = a; bus.arvalid = 1'b1; bus.rready = 1'b1;
    n = 0;
    while (bus.arvalid && n < 20) begin
      arr = bus.arready;
      @(posedge clk); #1;
      if (arr) bus.arvalid = 1'b0;
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!bus.rvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    e = rq.pop_front();
    if (n >= 20) begin
      check("rd_timeout", 32'(bus.rvalid), 32'd1);
      bus.arvalid = 1'b0;
    end else begin
      check("rdata", bus.rdata, e);
      check("rresp", 32'(bus.rresp), 32'd0);
    end
    @(posedge clk); #1;
    bus.rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    bus.awaddr = '0; bus.awprot = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    bus.araddr = '0; bus.arprot = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;

    // Reset state and first ready edge
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    check("rst_ctrl", ctrl, 32'd0);
    rst = 1'b0;
    #1 check("rel_awready", 32'(bus.awready), 32'd0);
    @(negedge clk);
    check("rel1_awready", 32'(bus.awready), 32'd1);
    check("rel1_wready", 32'(bus.wready), 32'd1);
    check("rel1_arready", 32'(bus.arready), 32'd1);

    // Basic register writes and reads
    axi_write(5'h00, 32'h1, 4'hF, 2'b00, 0);
    axi_write(5'h04, 32'h2, 4'hF, 2'b00, 0);
    axi_write(5'h08, 32'h3, 4'hF, 2'b00, 0);
    axi_write(5'h0C, 32'h4, 4'hF, 2'b00, 0);
    axi_read(5'h00, 32'h1);
    axi_read(5'h05, 32'h2);
    axi_read(5'h08, 32'h3);
    axi_read(5'h0C, 32'h4);
    check("out_ctrl", ctrl, 32'h1);
    check("out_threshold", threshold, 32'h2);
    check("out_window", window, 32'h3);
    check("out_scratch", scratch, 32'h4);

    // wstrb=0 leaves the word untouched
    axi_write(5'h08, 32'hFFFF_FFFF, 4'h0, 2'b00, 0);
    axi_read(5'h08, 32'h3);

    // W three cycles ahead of AW, partial strobes
    axi_write(5'h0C, 32'h0, 4'hF, 2'b00, 0);
    @(negedge clk);
    bus.wdata = 32'hAABB_CCDD; bus.wstrb = 4'b0101; bus.wvalid = 1'b1; bus.bready = 1'b1;
    @(posedge clk); #1 bus.wvalid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("wfirst_wready", 32'(bus.wready), 32'd0);
      check("wfirst_bvalid", 32'(bus.bvalid), 32'd0);
    end
    @(negedge clk);
    check("wfirst_awready", 32'(bus.awready), 32'd1);
    bus.awaddr = 5'h0C; bus.awvalid = 1'b1;
    @(posedge clk); #1 bus.awvalid = 1'b0;
    nb = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.bvalid) begin
        nb++;
        check("wfirst_bresp", 32'(bus.bresp), 32'd0);
      end
    end
    bus.bready = 1'b0;
    check("wfirst_bcount", 32'(nb), 32'd1);
    axi_read(5'h0C, 32'h00BB_00DD);

    // Back-pressured B channel
    axi_write(5'h04, 32'h1234_5678, 4'hF, 2'b00, 5);
    axi_read(5'h04, 32'h1234_5678);

    // Detection counter, status and clear-with-coincident-pulse
    @(negedge clk); det_pulse = 1'b1;
    repeat (10) @(negedge clk);
    det_pulse = 1'b0;
    axi_read(5'h10, 32'd10);
    det_busy = 1'b1;
    axi_read(5'h14, 32'h2);
    det_busy = 1'b0;
    det_pulse = 1'b1;
    axi_write(5'h00, 32'h2, 4'hF, 2'b00, 0);
    axi_read(5'h10, 32'd0);
    axi_read(5'h00, 32'd0);
    check("ctrl_selfclear", ctrl, 32'd0);
    @(negedge clk); det_pulse = 1'b1;
    repeat (3) @(negedge clk);
    det_pulse = 1'b0;

    // Unmapped and read-only words
    axi_write(5'h10, 32'hDEAD_BEEF, 4'hF, 2'b10, 0);
    axi_write(5'h1C, 32'hDEAD_BEEF, 4'hF, 2'b10, 0);
    axi_read(5'h10, 32'd3);
    axi_read(5'h18, 32'd0);
    axi_read(5'h14, 32'h0);

    // Reset with write response and read data both pending
    @(negedge clk);
    bus.araddr = 5'h04; bus.arvalid = 1'b1; bus.rready = 1'b0;
    @(posedge clk); #1 bus.arvalid = 1'b0;
    @(negedge clk);
    bus.awaddr = 5'h08; bus.awvalid = 1'b1; bus.wdata = 32'h77; bus.wstrb = 4'hF;
    bus.wvalid = 1'b1; bus.bready = 1'b0;
    @(posedge clk); #1 bus.awvalid = 1'b0; bus.wvalid = 1'b0;
    @(negedge clk);
    check("pre_rst_bvalid", 32'(bus.bvalid), 32'd1);
    check("pre_rst_rvalid", 32'(bus.rvalid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("mid_rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("mid_rst_rdata", bus.rdata, 32'd0);
    check("mid_rst_threshold", threshold, 32'd0);
    check("mid_rst_window", window, 32'd0);
    check("mid_rst_scratch", scratch, 32'd0);
    check("mid_rst_awready", 32'(bus.awready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_arready", 32'(bus.arready), 32'd1);
    axi_read(5'h04, 32'd0);
    axi_read(5'h10, 32'd0);
    axi_read(5'h08, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/packet_detector_axil_regs.md
PACKET_DETECTOR_AXIL_REGS -- requirements
Module: packet_detector_axil_regs

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 5, byte address width (8 words).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: s00_axi_aclk input 1, rising-edge clock for all logic.
REQ-004 s00_axi_areset input 1: asynchronous, active-high reset.
REQ-005 s00_axi_awaddr in C_S_AXI_ADDR_WIDTH; s00_axi_awprot in 3 (ignored); s00_axi_awvalid in 1; s00_axi_awready out 1.
REQ-006 s00_axi_wdata in 32; s00_axi_wstrb in 4; s00_axi_wvalid in 1; s00_axi_wready out 1.
REQ-007 s00_axi_bresp out 2; s00_axi_bvalid out 1; s00_axi_bready in 1.
REQ-008 s00_axi_araddr in C_S_AXI_ADDR_WIDTH; s00_axi_arprot in 3 (ignored); s00_axi_arvalid in 1; s00_axi_arready out 1.
REQ-009 s00_axi_rdata out 32; s00_axi_rresp out 2; s00_axi_rvalid out 1; s00_axi_rready in 1.
REQ-010 det_pulse in 1: one-cycle packet-detected strobe from detector core.
REQ-011 det_busy in 1: detector core busy level, readable in STATUS.
REQ-012 ctrl out 32, threshold out 32, window out 32, scratch out 32: direct register values to core.

Function
REQ-013 Word index = addr[4:2]; addr[1:0] ignored.
REQ-014 Map: 0 CTRL rw, 1 THRESHOLD rw, 2 WINDOW rw, 3 SCRATCH rw, 4 DET_COUNT ro, 5 STATUS ro ({30'b0, det_busy, count_saturated}), 6-7 unmapped.
REQ-015 Write FSM states W_IDLE, W_RESP; at most one write outstanding.
REQ-016 In W_IDLE, awready=1 until AW captured, wready=1 until W captured; AW and W accepted in either order or same cycle.
REQ-017 Edge after both AW and W captured: commit write, bvalid=1, enter W_RESP; awready=wready=0 in W_RESP.
REQ-018 W_RESP held, bresp stable, until bvalid&&bready, then W_IDLE; bready high on first cycle gives 1-cycle response.
REQ-019 Writes to words 0-3 update only bytes with wstrb[n]=1; wstrb=0 gives no change, bresp OKAY.
REQ-020 Writes to words 4-7 change nothing, bresp=2'b10 (SLVERR); otherwise bresp=2'b00.
REQ-021 CTRL bit1 is self-clearing: writing 1 clears DET_COUNT and count_saturated, CTRL[1] reads 0 thereafter.
REQ-022 Read FSM states R_IDLE, R_DATA; arready=1 only in R_IDLE.
REQ-023 On arvalid&&arready, rdata registered from addressed word at that edge, rvalid=1, enter R_DATA.
REQ-024 rdata/rresp held stable until rvalid&&rready, then R_IDLE; next AR accepted no earlier than following cycle.
REQ-025 Reads of words 6-7 return 0 with rresp OKAY; all other reads rresp OKAY.
REQ-026 Read and write channels independent; read capture on same edge as write commit to same word returns pre-write value.
REQ-027 DET_COUNT increments by 1 per det_pulse cycle; saturates at 0xFFFFFFFF and sets count_saturated (sticky).
REQ-028 Clear (REQ-021) coincident with det_pulse: clear wins, DET_COUNT=0.

Reset
REQ-029 Reset asserted: all registers, DET_COUNT, count_saturated = 0; FSMs to W_IDLE/R_IDLE; bvalid=rvalid=0, awready=wready=arready=0, rdata=0, bresp=rresp=0.
REQ-030 awready/wready/arready assert first rising edge after reset deassertion.
REQ-031 Reset mid-transaction discards captured AW/W/AR and pending responses with no partial register update.

Verification
REQ-032 Write 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C, bready=1 -> each bresp=0; reads return 0x1..0x4; ctrl=0x1, scratch=0x4.
REQ-033 W presented 3 cycles before AW to 0x0C, wdata 0xAABBCCDD, wstrb 4'b0101 from 0 -> SCRATCH=0x00BB00DD, single bvalid.
REQ-034 bready low 5 cycles -> bvalid held, bresp stable, awready/wready 0 until B handshake.
REQ-035 10 det_pulse cycles -> DET_COUNT=10; write CTRL=0x2 with coincident pulse -> DET_COUNT=0, CTRL reads 0.
REQ-036 Write to 0x10 -> bresp=2'b10, DET_COUNT unchanged; read 0x18 -> rdata=0, rresp=0.
REQ-037 Assert reset while bvalid=1 with rready low on pending read -> bvalid=rvalid=0 immediately, all registers 0.
